// File: rtl/sd_pkg.sv
// Shared SD slave definitions: command frame geometry, CRC7 polynomial,
// receiver state encoding and the serial CRC7 update step.
package sd_pkg;

  localparam int unsigned SD_CMD_BITS  = 48;
  localparam int unsigned SD_IDX_W     = 6;
  localparam int unsigned SD_ARG_W     = 32;
  localparam int unsigned SD_CRC_W     = 7;
  localparam logic [6:0]  SD_CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRANS,
    ST_BODY,
    ST_CRC,
    ST_END
  } sd_cmd_state_e;

  // One bit of x^7+x^3+1, MSB-first.
  function automatic logic [6:0] sd_crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 engine; clr with en seeds the register from zero with din.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      crc_d = sd_crc7_step(clr ? 7'h00 : crc_q, din);
    end else if (clr) begin
      crc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_slv_cmd_rx.sv
// SD slave command receiver: deserialises the 48-bit host command frame,
// checks transmission/end bits and CRC7, and presents index and argument.
module sd_slv_cmd_rx
  import sd_pkg::*;
#(
  parameter int unsigned FRM_BITS = SD_CMD_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cmd_i,
  input  logic                cmd_oe,
  output logic                busy,
  output logic                cmd_vld,
  output logic [SD_IDX_W-1:0] cmd_idx,
  output logic [SD_ARG_W-1:0] cmd_arg,
  output logic                crc_err,
  output logic                end_err
);

  localparam int unsigned BODY_BITS = FRM_BITS - SD_CRC_W - 3;
  localparam logic [5:0]  BODY_LD   = 6'(BODY_BITS);
  localparam logic [5:0]  CRC_LD    = 6'(SD_CRC_W - 1);

  sd_cmd_state_e          state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [BODY_BITS-1:0]   sh_q, sh_d;
  logic [SD_CRC_W-1:0]    rx_crc_q, rx_crc_d;
  logic                   cmd_vld_q, cmd_vld_d;
  logic [SD_IDX_W-1:0]    cmd_idx_q, cmd_idx_d;
  logic [SD_ARG_W-1:0]    cmd_arg_q, cmd_arg_d;
  logic                   crc_err_q, crc_err_d;
  logic                   end_err_q, end_err_d;

  logic                   start, abort, crc_en;
  logic [SD_CRC_W-1:0]    calc_crc;

  assign start  = (state_q == ST_IDLE) && en && !cmd_oe && !cmd_i;
  assign abort  = !en || cmd_oe;
  assign crc_en = start || (!abort && (state_q == ST_TRANS || state_q == ST_BODY));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (crc_en),
    .din   (cmd_i),
    .crc   (calc_crc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rx_crc_d  = rx_crc_q;
    cmd_vld_d = 1'b0;
    cmd_idx_d = cmd_idx_q;
    cmd_arg_d = cmd_arg_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_TRANS;
        ST_TRANS: begin
          if (cmd_i) begin
            cnt_d   = BODY_LD;
            state_d = ST_BODY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // BODY tests the post-decrement count, CRC the current one, so the
        // 38/6 loads yield exactly 38 body bits and 7 CRC bits.
        ST_BODY: begin
          sh_d  = {sh_q[BODY_BITS-2:0], cmd_i};
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            cnt_d   = CRC_LD;
            state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          rx_crc_d = {rx_crc_q[SD_CRC_W-2:0], cmd_i};
          if (cnt_q == 6'd0) state_d = ST_END;
          else               cnt_d   = cnt_q - 6'd1;
        end
        ST_END: begin
          cmd_idx_d = sh_q[BODY_BITS-1 -: SD_IDX_W];
          cmd_arg_d = sh_q[SD_ARG_W-1:0];
          crc_err_d = (rx_crc_q != calc_crc);
          end_err_d = !cmd_i;
          cmd_vld_d = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rx_crc_q  <= '0;
      cmd_vld_q <= 1'b0;
      cmd_idx_q <= '0;
      cmd_arg_q <= '0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rx_crc_q  <= rx_crc_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_idx_q <= cmd_idx_d;
      cmd_arg_q <= cmd_arg_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign cmd_vld = cmd_vld_q;
  assign cmd_idx = cmd_idx_q;
  assign cmd_arg = cmd_arg_q;
  assign crc_err = crc_err_q;
  assign end_err = end_err_q;

endmodule

// File: tb/tb_sd_slv_cmd_rx.sv
// Self-checking bench for sd_slv_cmd_rx: directed command frames, aborts and
// randomized frames against a polynomial-division reference of the frame rules.
module tb_sd_slv_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n, en, cmd_i, cmd_oe;
  logic        busy, cmd_vld, crc_err, end_err;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [5:0]  exp_idx = '0;
  logic [31:0] exp_arg = '0;
  logic        exp_ce  = 1'b0;
  logic        exp_ee  = 1'b0;
  int unsigned exp_vld_cnt = 0;

  int unsigned cyc = 0, vld_cnt = 0, last_vld_cyc = 0, prev_vld_cyc = 0;

  sd_slv_cmd_rx #(.FRM_BITS(48)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cmd_i   (cmd_i),
    .cmd_oe  (cmd_oe),
    .busy    (busy),
    .cmd_vld (cmd_vld),
    .cmd_idx (cmd_idx),
    .cmd_arg (cmd_arg),
    .crc_err (crc_err),
    .end_err (end_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (cmd_vld === 1'b1) begin
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
      vld_cnt++;
    end
  end

  // Remainder of (bits 47..8) * x^7 modulo x^7+x^3+1 (0x89).
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  task automatic set_exp(input logic [47:0] f);
    exp_idx = f[45:40];
    exp_arg = f[39:8];
    exp_ce  = (f[7:1] != ref_crc7(f[47:8]));
    exp_ee  = !f[0];
    exp_vld_cnt++;
  endtask

  task automatic drive_bits(input logic [47:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cmd_i = f[i];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    cmd_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== 42'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {busy, cmd_vld, cmd_idx, cmd_arg, crc_err, end_err});
    end
    rst_n = 1'b1;
    en    = 1'b1;
    idle(2);
  endtask

  task automatic test_cmd0;
    logic [47:0] f;
    f = 48'h40_0000_0000_95;
    set_exp(f);
    drive_bits(f, 47, 47);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL cmd0_busy: got %b want 1", busy);
    end
    drive_bits(f, 46, 0);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, 6'd0, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL cmd0_out: got %h want %h", {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
               {1'b1, 6'd0, 32'd0, 1'b0, 1'b0});
    end
    idle(1);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg} !== {1'b0, exp_idx, exp_arg}) begin
      n_bad++; $display("FAIL cmd0_strobe_hold: got %h want %h", {cmd_vld, cmd_idx, cmd_arg}, {1'b0, exp_idx, exp_arg});
    end
    idle(3);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL cmd0_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] f8, f17;
    f8  = 48'h48_0000_01AA_87;
    f17 = 48'h51_0000_0000_55;
    set_exp(f8);
    drive_bits(f8, 47, 0);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL cmd8_out: got %h want %h", {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
               {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0});
    end
    set_exp(f17);
    drive_bits(f17, 47, 0);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, 6'd17, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL cmd17_out: got %h want %h", {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
               {1'b1, 6'd17, 32'd0, 1'b0, 1'b0});
    end
    idle(3);
    n_cmp++;
    if (last_vld_cyc - prev_vld_cyc !== 48) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d want 48", last_vld_cyc - prev_vld_cyc);
    end
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt) begin
      n_bad++; $display("FAIL b2b_vld_count: got %0d want %0d", vld_cnt, exp_vld_cnt);
    end
  endtask

  task automatic test_errors;
    logic [47:0] f;
    f = 48'h40_0000_0000_97;
    set_exp(f);
    drive_bits(f, 47, 0);
    n_cmp++;
    if ({cmd_vld, crc_err, end_err} !== 3'b110) begin
      n_bad++; $display("FAIL bad_crc: got %b want 110", {cmd_vld, crc_err, end_err});
    end
    idle(2);
    f = 48'h40_0000_0000_94;
    set_exp(f);
    drive_bits(f, 47, 0);
    n_cmp++;
    if ({cmd_vld, crc_err, end_err} !== 3'b101) begin
      n_bad++; $display("FAIL bad_end: got %b want 101", {cmd_vld, crc_err, end_err});
    end
    idle(2);
  endtask

  task automatic test_resp_frame;
    cmd_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL resp_busy_start: got %b want 1", busy);
    end
    cmd_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL resp_busy_drop: got %b want 0", busy);
    end
    idle(50);
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt || {cmd_idx, cmd_arg, crc_err, end_err} !== {exp_idx, exp_arg, exp_ce, exp_ee}) begin
      n_bad++;
      $display("FAIL resp_no_vld: got cnt %0d out %h want cnt %0d out %h", vld_cnt,
               {cmd_idx, cmd_arg, crc_err, end_err}, exp_vld_cnt, {exp_idx, exp_arg, exp_ce, exp_ee});
    end
  endtask

  task automatic test_suppress;
    cmd_oe = 1'b1;
    cmd_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++; $display("FAIL suppress_busy: got %b want 0", busy);
      end
    end
    cmd_oe = 1'b0;
    idle(5);
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt) begin
      n_bad++; $display("FAIL suppress_no_vld: got %0d want %0d", vld_cnt, exp_vld_cnt);
    end
  endtask

  task automatic test_abort_en;
    logic [47:0] f;
    f = 48'h48_0000_01AA_87;
    drive_bits(f, 47, 28);
    cmd_i = f[27];
    en    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_en_idle: got %b want 0", busy);
    end
    drive_bits(f, 26, 0);
    idle(2);
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt || {cmd_idx, cmd_arg, crc_err, end_err} !== {exp_idx, exp_arg, exp_ce, exp_ee}) begin
      n_bad++;
      $display("FAIL abort_en_hold: got cnt %0d out %h want cnt %0d out %h", vld_cnt,
               {cmd_idx, cmd_arg, crc_err, end_err}, exp_vld_cnt, {exp_idx, exp_arg, exp_ce, exp_ee});
    end
    en = 1'b1;
    idle(2);
    set_exp(f);
    drive_bits(f, 47, 0);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_en_recover: got %h want %h", {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
               {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0});
    end
    idle(2);
  endtask

  task automatic test_abort_rst;
    logic [47:0] f;
    f = 48'h48_0000_01AA_87;
    drive_bits(f, 47, 18);
    rst_n = 1'b0;
    cmd_i = 1'b1;
    #1;
    n_cmp++;
    if ({busy, cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== 42'd0) begin
      n_bad++;
      $display("FAIL abort_rst_clear: got %h want 0", {busy, cmd_vld, cmd_idx, cmd_arg, crc_err, end_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_idx = '0; exp_arg = '0; exp_ce = 1'b0; exp_ee = 1'b0;
    idle(20);
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt || {busy, cmd_idx, cmd_arg, crc_err, end_err} !== 41'd0) begin
      n_bad++;
      $display("FAIL abort_rst_idle: got cnt %0d out %h want cnt %0d out 0", vld_cnt,
               {busy, cmd_idx, cmd_arg, crc_err, end_err}, exp_vld_cnt);
    end
    set_exp(f);
    drive_bits(f, 47, 0);
    n_cmp++;
    if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_rst_recover: got %h want %h", {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
               {1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0});
    end
    idle(2);
  endtask

  task automatic test_random;
    logic [47:0] f;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        endb;
    int          b, gap;
    for (int k = 0; k < 60; k++) begin
      idx  = 6'($urandom);
      arg  = $urandom;
      crc  = ref_crc7({2'b01, idx, arg});
      if ($urandom_range(0, 3) == 0) crc = crc ^ 7'($urandom_range(1, 127));
      endb = ($urandom_range(0, 5) != 0);
      f    = {2'b01, idx, arg, crc, endb};
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(1, 47);
        drive_bits(f, 47, 48 - b);
        cmd_oe = 1'b1;
        cmd_i  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cmd_vld !== 1'b0) begin
          n_bad++; $display("FAIL rnd_oe_abort: got busy %b vld %b want 0 0 (bit %0d)", busy, cmd_vld, b);
        end
        cmd_oe = 1'b0;
        idle(1);
      end else begin
        set_exp(f);
        drive_bits(f, 47, 0);
        n_cmp++;
        if ({cmd_vld, cmd_idx, cmd_arg, crc_err, end_err} !== {1'b1, exp_idx, exp_arg, exp_ce, exp_ee}) begin
          n_bad++;
          $display("FAIL rnd_frame_%0d: got %h want %h", k, {cmd_vld, cmd_idx, cmd_arg, crc_err, end_err},
                   {1'b1, exp_idx, exp_arg, exp_ce, exp_ee});
        end
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
      end
    end
    idle(4);
    n_cmp++;
    if (vld_cnt !== exp_vld_cnt || {cmd_idx, cmd_arg, crc_err, end_err} !== {exp_idx, exp_arg, exp_ce, exp_ee}) begin
      n_bad++;
      $display("FAIL rnd_final: got cnt %0d out %h want cnt %0d out %h", vld_cnt,
               {cmd_idx, cmd_arg, crc_err, end_err}, exp_vld_cnt, {exp_idx, exp_arg, exp_ce, exp_ee});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    cmd_i  = 1'b1;
    cmd_oe = 1'b0;
    test_reset;
    test_cmd0;
    test_back_to_back;
    test_errors;
    test_resp_frame;
    test_suppress;
    test_abort_en;
    test_abort_rst;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
